// File: rtl/logicunit_checker_pkg.sv
// Shared definitions for the logic-unit checker: operation codes and checker run states.
package logicunit_checker_pkg;

   typedef enum logic [1:0] {
      LU_AND = 2'd0,
      LU_OR  = 2'd1,
      LU_NOR = 2'd2,
      LU_XOR = 2'd3
   } lu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_e;

   // A run is in progress while vectors are accepted or still travelling down the delay line
   function automatic logic is_busy_state(chk_state_e s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/logicunit_ref.sv
// Combinational golden model of the logic unit; reused by other benches as the reference.
module logicunit_ref
   import logicunit_checker_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       control,
   output logic [WIDTH-1:0] out
);

   // Bitwise operation selected by control
   always_comb begin
      out = '0;
      case (lu_op_e'(control))
         LU_AND:  out = a & b;
         LU_OR:   out = a | b;
         LU_NOR:  out = ~(a | b);
         LU_XOR:  out = a ^ b;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/logicunit_checker.sv
// Response checker for the logic unit: aligns golden results to the DUT latency, compares,
// counts vectors and mismatches, captures the first failure and reports through start/done.
module logicunit_checker
   import logicunit_checker_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       control,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [1:0]       first_err_ctrl,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_got
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   chk_state_e       state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             first_err_valid_q, first_err_valid_d;
   logic [1:0]       first_err_ctrl_q, first_err_ctrl_d;
   logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
   logic [WIDTH-1:0] first_err_got_q, first_err_got_d;

   logic             run_entry;
   logic             accept;
   logic [WIDTH-1:0] ref_out;
   logic             cmp_valid;
   logic [1:0]       cmp_ctrl;
   logic [WIDTH-1:0] cmp_exp;
   logic             pending_next;
   logic             mismatch;

   assign run_entry = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign accept    = in_valid && (state_q == ST_RUN);

   logicunit_ref #(.WIDTH(WIDTH)) u_ref (
      .a       (a),
      .b       (b),
      .control (control),
      .out     (ref_out)
   );

   if (LATENCY == 0) begin : g_no_delay
      // Zero-latency DUT: the vector being accepted is compared in the same cycle
      assign cmp_valid    = accept;
      assign cmp_ctrl     = control;
      assign cmp_exp      = ref_out;
      assign pending_next = 1'b0;
   end else begin : g_delay
      logic [LATENCY-1:0]            dl_valid_q, dl_valid_d;
      logic [LATENCY-1:0][1:0]       dl_ctrl_q, dl_ctrl_d;
      logic [LATENCY-1:0][WIDTH-1:0] dl_exp_q, dl_exp_d;

      // Shift expected results one stage per cycle; flushed when a new run begins
      always_comb begin
         dl_valid_d = dl_valid_q;
         dl_ctrl_d  = dl_ctrl_q;
         dl_exp_d   = dl_exp_q;
         if (run_entry) begin
            dl_valid_d = '0;
            dl_ctrl_d  = '0;
            dl_exp_d   = '0;
         end else begin
            dl_valid_d[0] = accept;
            dl_ctrl_d[0]  = control;
            dl_exp_d[0]   = ref_out;
            for (int i = 1; i < LATENCY; i++) begin
               dl_valid_d[i] = dl_valid_q[i-1];
               dl_ctrl_d[i]  = dl_ctrl_q[i-1];
               dl_exp_d[i]   = dl_exp_q[i-1];
            end
         end
      end

      // Delay-line registers
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            dl_valid_q <= '0;
            dl_ctrl_q  <= '0;
            dl_exp_q   <= '0;
         end else begin
            dl_valid_q <= dl_valid_d;
            dl_ctrl_q  <= dl_ctrl_d;
            dl_exp_q   <= dl_exp_d;
         end
      end

      assign cmp_valid    = dl_valid_q[LATENCY-1];
      assign cmp_ctrl     = dl_ctrl_q[LATENCY-1];
      assign cmp_exp      = dl_exp_q[LATENCY-1];
      // Anything still in flight after this edge keeps the run draining
      assign pending_next = |dl_valid_d;
   end

   assign mismatch = cmp_valid && (dut_out != cmp_exp);

   // Run sequencing: IDLE/DONE wait for start, RUN waits for stop, DRAIN empties the delay line
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
         ST_RUN:           if (stop) state_d = pending_next ? ST_DRAIN : ST_DONE;
         ST_DRAIN:         if (!pending_next) state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // Saturating counters, sticky first-error capture and status flags
   always_comb begin
      vec_count_d       = vec_count_q;
      err_count_d       = err_count_q;
      first_err_valid_d = first_err_valid_q;
      first_err_ctrl_d  = first_err_ctrl_q;
      first_err_exp_d   = first_err_exp_q;
      first_err_got_d   = first_err_got_q;
      if (run_entry) begin
         vec_count_d       = '0;
         err_count_d       = '0;
         first_err_valid_d = 1'b0;
         first_err_ctrl_d  = '0;
         first_err_exp_d   = '0;
         first_err_got_d   = '0;
      end else if (cmp_valid && is_busy_state(state_q)) begin
         if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + CNT_W'(1);
         if (mismatch) begin
            if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
            if (!first_err_valid_q) begin
               first_err_valid_d = 1'b1;
               first_err_ctrl_d  = cmp_ctrl;
               first_err_exp_d   = cmp_exp;
               first_err_got_d   = dut_out;
            end
         end
      end
      busy_d = is_busy_state(state_d);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (err_count_d == '0);
   end

   // State and result registers; reset aborts any run without reporting done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= ST_IDLE;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         pass_q            <= 1'b0;
         vec_count_q       <= '0;
         err_count_q       <= '0;
         first_err_valid_q <= 1'b0;
         first_err_ctrl_q  <= '0;
         first_err_exp_q   <= '0;
         first_err_got_q   <= '0;
      end else begin
         state_q           <= state_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         pass_q            <= pass_d;
         vec_count_q       <= vec_count_d;
         err_count_q       <= err_count_d;
         first_err_valid_q <= first_err_valid_d;
         first_err_ctrl_q  <= first_err_ctrl_d;
         first_err_exp_q   <= first_err_exp_d;
         first_err_got_q   <= first_err_got_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign vec_count       = vec_count_q;
   assign err_count       = err_count_q;
   assign first_err_valid = first_err_valid_q;
   assign first_err_ctrl  = first_err_ctrl_q;
   assign first_err_exp   = first_err_exp_q;
   assign first_err_got   = first_err_got_q;

endmodule
